// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
// Used by md_sequencer, md_arith and the decoder/controller that produces md_op.
//   - md_op encoding (3-bit op width)
//   - default busy latencies for multiply and divide
package md_pkg;

  localparam int MD_OP_W = 3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Codes 0 and 7 are no-ops.
  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_md_arith(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: purely combinational multiply/divide datapath.
// Ports:
//   op       in   3  latched operation (md_op_e encoding)
//   a        in  32  latched operand A (rs)
//   b        in  32  latched operand B (rt)
//   res      out 64  {hi_next, lo_next}
//   div_zero out  1  DIV/DIVU with a zero divisor; HI/LO must not be written
module md_arith
  import md_pkg::*;
(
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  output logic [63:0]        res,
  output logic               div_zero
);

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_mag_safe;
  logic [31:0] b_safe;
  logic [31:0] sq_mag;
  logic [31:0] sr_mag;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [63:0] a_sext;
  logic [63:0] b_sext;
  logic [63:0] a_zext;
  logic [63:0] b_zext;

  // Signed division is done on magnitudes so the truncate-toward-zero and
  // remainder-sign rules do not depend on the tool's signed '/' semantics.
  // 0x80000000 has magnitude 0x80000000 as an unsigned value, so the
  // 0x80000000 / -1 overflow case naturally yields LO=0x80000000, HI=0.
  assign a_neg = a[31];
  assign b_neg = b[31];
  assign a_mag = a_neg ? (32'd0 - a) : a;
  assign b_mag = b_neg ? (32'd0 - b) : b;

  // Divisors of zero are replaced by one so the dividers never see zero;
  // the result is discarded by the sequencer in that case anyway.
  assign b_mag_safe = (b == 32'd0) ? 32'd1 : b_mag;
  assign b_safe     = (b == 32'd0) ? 32'd1 : b;

  assign sq_mag = a_mag / b_mag_safe;
  assign sr_mag = a_mag % b_mag_safe;
  assign uq     = a / b_safe;
  assign ur     = a % b_safe;

  // The low 64 bits of a product are the same for signed and unsigned
  // multiplication once the operands are extended appropriately.
  assign a_sext = {{32{a[31]}}, a};
  assign b_sext = {{32{b[31]}}, b};
  assign a_zext = {32'd0, a};
  assign b_zext = {32'd0, b};

  // NOTE: every output is given a default before the case so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    res      = '0;
    div_zero = 1'b0;
    case (op)
      MD_MULT:  res = a_sext * b_sext;
      MD_MULTU: res = a_zext * b_zext;
      MD_DIV: begin
        div_zero = (b == 32'd0);
        res = {(a_neg ? (32'd0 - sr_mag) : sr_mag),
               ((a_neg ^ b_neg) ? (32'd0 - sq_mag) : sq_mag)};
      end
      MD_DIVU: begin
        div_zero = (b == 32'd0);
        res      = {ur, uq};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: multiply/divide sequencer owning the HI/LO registers.
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage, models fixed
// latencies with a busy counter and requests D-stage stalls for MD-class
// instructions while the unit is occupied.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   start       E-stage instruction is an MD op this cycle
//   md_op       operation code (md_pkg::md_op_e)
//   rs_val      operand A / MTHI, MTLO source
//   rt_val      operand B
//   rd_sel      read port select: 0 = HI, 1 = LO
//   md_use_D    D-stage instruction is MD-class
//   hi, lo      HI/LO registers
//   md_rdata    combinational rd_sel ? lo : hi
//   busy        multi-cycle operation in progress
//   stall_md    stall request to the hazard unit
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [31:0]        rs_val,
  input  logic [31:0]        rt_val,
  input  logic               rd_sel,
  input  logic               md_use_D,
  output logic [31:0]        hi,
  output logic [31:0]        lo,
  output logic [31:0]        md_rdata,
  output logic               busy,
  output logic               stall_md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0]   cnt_q,  cnt_d;
  logic [MD_OP_W-1:0] op_q,   op_d;
  logic [31:0]        a_q,    a_d;
  logic [31:0]        b_q,    b_d;
  logic [31:0]        hi_q,   hi_d;
  logic [31:0]        lo_q,   lo_d;

  logic [63:0]        arith_res;
  logic               div_zero;
  logic               accept;

  md_arith u_arith (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .res      (arith_res),
    .div_zero (div_zero)
  );

  assign busy     = (cnt_q != '0);
  assign accept   = start && !busy;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign md_rdata = rd_sel ? lo_q : hi_q;

  // Asserted in the accept cycle itself so the following MD-class
  // instruction never slips into E while the unit is about to go busy.
  assign stall_md = md_use_D && (busy || (start && is_md_arith(md_op)));

  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;

    if (accept) begin
      case (md_op)
        MD_MULT, MD_MULTU: begin
          op_d  = md_op;
          a_d   = rs_val;
          b_d   = rt_val;
          cnt_d = CNT_W'(MULT_CYCLES);
        end
        MD_DIV, MD_DIVU: begin
          op_d  = md_op;
          a_d   = rs_val;
          b_d   = rt_val;
          cnt_d = CNT_W'(DIV_CYCLES);
        end
        MD_MTHI: hi_d = rs_val;
        MD_MTLO: lo_d = rs_val;
        default: ;
      endcase
    end else if (busy) begin
      cnt_d = cnt_q - CNT_W'(1);
      // Results land on the last busy edge; a zero divisor leaves HI/LO alone
      // while still spending the full latency.
      if ((cnt_q == CNT_W'(1)) && !div_zero) begin
        {hi_d, lo_d} = arith_res;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= MD_NONE;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer. Stimulus pushes the expected
// completion (HI, LO, busy length) into a queue; a monitor pops and compares
// each time busy falls. Immediate effects (MT*, stall, reset) are checked
// directly from the stimulus thread.
module tb_md_sequencer;
  import md_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic               clk;
  logic               reset;
  logic               start;
  logic [MD_OP_W-1:0] md_op;
  logic [31:0]        rs_val;
  logic [31:0]        rt_val;
  logic               rd_sel;
  logic               md_use_D;
  logic [31:0]        hi;
  logic [31:0]        lo;
  logic [31:0]        md_rdata;
  logic               busy;
  logic               stall_md;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .rd_sel   (rd_sel),
    .md_use_D (md_use_D),
    .hi       (hi),
    .lo       (lo),
    .md_rdata (md_rdata),
    .busy     (busy),
    .stall_md (stall_md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: measure each busy window and compare HI/LO when it closes.
  int   mon_len  = 0;
  logic mon_prev = 1'b0;
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_len  = 0;
        mon_prev = 1'b0;
      end else begin
        if (busy) begin
          mon_len++;
        end else if (mon_prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected completion", 64'd1, 64'd0);
          end else begin
            mon_e = exp_q.pop_front();
            check({mon_e.name, " busy cycles"}, 64'(mon_len), 64'(mon_e.cycles));
            check({mon_e.name, " hi"}, {32'd0, hi}, {32'd0, mon_e.hi});
            check({mon_e.name, " lo"}, {32'd0, lo}, {32'd0, mon_e.lo});
          end
          mon_len = 0;
        end
        mon_prev = busy;
      end
    end
  end

  // Called at posedge+1 (cycle T); returns at posedge+1 of cycle T+1 with the
  // operands scrambled so that only latched values can produce the result.
  task automatic issue(input logic [MD_OP_W-1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit push, input string name,
                       input logic [31:0] ehi, input logic [31:0] elo, input int cyc);
    exp_t e;
    start  = 1'b1;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    if (push) begin
      e.name = name; e.hi = ehi; e.lo = elo; e.cycles = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    start  = 1'b0;
    md_op  = MD_NONE;
    rs_val = ~a;
    rt_val = ~b;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("completion within budget", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = MD_NONE; rs_val = '0; rt_val = '0;
    rd_sel = 1'b0; md_use_D = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset stall", {63'd0, stall_md}, 64'd0);
    check("reset rdata", {32'd0, md_rdata}, 64'd0);

    // MULT then MULTU issued in the first non-busy cycle (no bubble)
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1, "mult -2*3", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    repeat (5) begin @(posedge clk); #1; end
    issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1, "multu fffffffe*3", 32'h0000_0002, 32'hFFFF_FFFA, 5);
    wait_idle(40);
    rd_sel = 1'b0; #1;
    check("mfhi after multu", {32'd0, md_rdata}, 64'h2);
    rd_sel = 1'b1; #1;
    check("mflo after multu", {32'd0, md_rdata}, 64'hFFFF_FFFA);

    // More multiply/divide vectors
    issue(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "mult -1*-1", 32'h0, 32'h1, 5);
    wait_idle(40);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "multu max*max", 32'hFFFF_FFFE, 32'h1, 5);
    wait_idle(40);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1, "div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    wait_idle(40);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1, "div -7/-2", 32'hFFFF_FFFF, 32'h3, 10);
    wait_idle(40);
    issue(MD_DIV, 32'd7, 32'hFFFF_FFFE, 1, "div 7/-2", 32'h1, 32'hFFFF_FFFD, 10);
    wait_idle(40);

    // DIVU 7/2 and an MFHI read in the very first cycle after completion
    issue(MD_DIVU, 32'd7, 32'd2, 1, "divu 7/2", 32'h1, 32'h3, 10);
    repeat (10) begin @(posedge clk); #1; end
    rd_sel = 1'b0; #1;
    check("mfhi right after divu", {32'd0, md_rdata}, 64'h1);
    check("busy low after divu", {63'd0, busy}, 64'd0);
    wait_idle(40);

    // MTHI/MTLO, each visible next cycle without going busy
    issue(MD_MTHI, 32'h11, 32'h0, 0, "", 32'h0, 32'h0, 0);
    rd_sel = 1'b0; #1;
    check("mthi hi", {32'd0, hi}, 64'h11);
    check("mthi rdata", {32'd0, md_rdata}, 64'h11);
    check("mthi busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    issue(MD_MTLO, 32'h22, 32'h0, 0, "", 32'h0, 32'h0, 0);
    rd_sel = 1'b1; #1;
    check("mtlo lo", {32'd0, lo}, 64'h22);
    check("mtlo rdata", {32'd0, md_rdata}, 64'h22);
    @(posedge clk); #1;

    // Divide by zero: full latency, HI/LO unchanged
    issue(MD_DIV, 32'd5, 32'd0, 1, "div by zero", 32'h11, 32'h22, 10);
    wait_idle(40);
    issue(MD_DIVU, 32'd9, 32'd0, 1, "divu by zero", 32'h11, 32'h22, 10);
    wait_idle(40);

    // Stall behaviour with a second start during busy
    md_use_D = 1'b1;
    start = 1'b1; md_op = MD_MULT; rs_val = 32'd5; rt_val = 32'd7;
    exp_q.push_back('{name: "mult under stall", hi: 32'h0, lo: 32'd35, cycles: 5});
    #1;
    check("stall cycle T", {63'd0, stall_md}, 64'd1);
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE;
    for (int i = 1; i <= 5; i++) begin
      if (i == 2) begin
        start = 1'b1; md_op = MD_DIV; rs_val = 32'd100; rt_val = 32'd3;
      end else begin
        start = 1'b0; md_op = MD_NONE;
      end
      #1;
      check($sformatf("stall busy cycle T+%0d", i), {63'd0, stall_md}, 64'd1);
      @(posedge clk); #1;
    end
    start = 1'b0; md_op = MD_NONE;
    #1;
    check("stall released T+6", {63'd0, stall_md}, 64'd0);
    md_use_D = 1'b0;
    wait_idle(40);

    // Reset in the middle of a DIV aborts it
    issue(MD_DIV, 32'd100, 32'd7, 0, "", 32'h0, 32'h0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort hi", {32'd0, hi}, 64'd0);
    check("abort lo", {32'd0, lo}, 64'd0);
    reset = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    check("no late write hi", {32'd0, hi}, 64'd0);
    check("no late write lo", {32'd0, lo}, 64'd0);
    check("no late busy", {63'd0, busy}, 64'd0);

    // Signed overflow divide
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, "div min/-1", 32'h0, 32'h8000_0000, 10);
    wait_idle(40);
    check("queue drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound on the whole run.
  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multiply/divide sequencer for the five-stage pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and owns the HI/LO registers. It models fixed multi-cycle latencies with a busy counter and drives the D-stage stall request while an MD-class instruction must wait. The HI/LO read port (MFHI/MFLO) feeds the value that the E/M pipeline register carries forward.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  E-stage instruction is an MD op this cycle
- md_op  in  3  operation code, from shared package
- rs_val  in  32  forwarded operand A
- rt_val  in  32  forwarded operand B
- rd_sel  in  1  0 = HI, 1 = LO, for the read port
- md_use_D  in  1  D-stage instruction is MD-class (mult/div/mt*/mf*)
- hi  out  32  HI register
- lo  out  32  LO register
- md_rdata  out  32  combinational rd_sel ? lo : hi
- busy  out  1  operation in progress
- stall_md  out  1  stall request to hazard unit

## Operation
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; values 7 and NONE are no-ops.
- Accept condition: start && !busy. A start while busy is ignored; the hazard unit prevents it.
- Accepted MULT/MULTU: latch operands, load the counter with MULT_CYCLES.
- Accepted DIV/DIVU: latch operands, load the counter with DIV_CYCLES.
- Accepted MTHI/MTLO: write rs_val into HI or LO at that edge. Counter unchanged, busy stays 0.
- busy = (cnt != 0). The counter decrements each cycle while nonzero. At the edge where cnt==1, HI/LO are written from the latched operands.
- MULT: signed 64-bit product, {HI,LO}. MULTU: unsigned 64-bit product.
- DIV: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero: HI and LO are unchanged at completion. The busy timing is still the full DIV_CYCLES.
- stall_md = md_use_D && (busy || (start && md_op in MULT..DIVU)).
- The result is computed from the latched operands. Operand input changes after acceptance have no effect.
- Reset values: hi=0, lo=0, cnt=0, busy=0, stall_md=0 (given md_use_D=0), latched operands=0.
- Reset mid-operation aborts it: counter cleared, no HI/LO write.

## Timing
- Accept MULT at edge T (start high in cycle T).
  - busy is high in cycles T+1 .. T+MULT_CYCLES.
  - HI/LO are updated at the end of cycle T+MULT_CYCLES.
  - New values are visible, with busy=0, in cycle T+MULT_CYCLES+1.
- DIV behaves the same with DIV_CYCLES.
- MTHI/MTLO: the value is visible on hi/lo and md_rdata in cycle T+1.
- The first cycle after busy falls accepts a new start; there is no bubble beyond the stall.
- stall_md is combinational from inputs and busy, with no register delay. It is asserted in cycle T itself if the D-stage instruction is MD-class.
- md_rdata is combinational. During busy it shows the old HI/LO; the stall guarantees no MF* reads them.

## Structure
- Shared package md_pkg holds:
  - the md_op encoding constants,
  - default MULT_CYCLES/DIV_CYCLES,
  - the 3-bit op width.
- The same package is used by the decoder/controller that generates md_op.
- One natural sub-module, md_arith: purely combinational. It takes the latched op and operands and returns 64-bit {hi_next, lo_next} plus a div_zero flag.
- The sequencer holds the counter, the operand/op latches and HI/LO.

## Test plan
- Reset, then MULT rs=0xFFFFFFFE (−2), rt=3. Required: busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (−7), rt=2. Required: busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 gives LO=3, HI=1.
- Preload HI=0x11, LO=0x22 via MTHI/MTLO, each visible the next cycle. Then DIV by 0. Required: HI/LO remain 0x11/0x22 after 10 busy cycles.
- MULT started with md_use_D=1 held. Required: stall_md high in cycle T and in every busy cycle, then low in cycle T+6. A second start during busy leaves HI/LO and the counter unaffected.
- Assert reset at cycle T+3 of a DIV. Required: busy=0, hi=lo=0 the next cycle, and no late write appears afterward.
- Edge cases:
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - MFHI read via rd_sel=0 right after completion returns the new HI.
